// File: rtl/vc_plane_scheduler_if.sv
// vc_plane_scheduler_if
// Purpose : bundles the VC-plane request side and the switch handshake of the
//           VC plane scheduler.
// Signals : vcRequest/vcTail  - per-plane flit-pending and tail flags
//           switchReady       - switch accepts the presented flit
//           VCPlaneSelector   - binary index of the active plane (VC+1 bits)
//           vcGrant           - one-hot owner of the switch
//           vcReady           - switchReady routed to the owning plane
//           switchValid       - flit presented to the switch
//           schedulerBusy     - a packet is locked
// Modports: master = scheduler side, slave = planes/switch side.
interface vc_plane_scheduler_if #(
  parameter int unsigned VC = 4
);
  logic [VC-1:0] vcRequest;
  logic [VC-1:0] vcTail;
  logic          switchReady;
  logic [VC:0]   VCPlaneSelector;
  logic [VC-1:0] vcGrant;
  logic [VC-1:0] vcReady;
  logic          switchValid;
  logic          schedulerBusy;

  modport master (
    input  vcRequest, vcTail, switchReady,
    output VCPlaneSelector, vcGrant, vcReady, switchValid, schedulerBusy
  );

  modport slave (
    output vcRequest, vcTail, switchReady,
    input  VCPlaneSelector, vcGrant, vcReady, switchValid, schedulerBusy
  );
endinterface

// File: rtl/vc_plane_scheduler.sv
// vc_plane_scheduler
// Purpose : round-robin arbitration among VC planes with a pending flit; the
//           winner owns the switch from head to tail (wormhole lock). Drives
//           the plane index to the switch-control mux and the flit valid to
//           the switch, and routes switchReady back to the owning plane only.
// Ports   : clk, rst (synchronous, active-high)
//           bus (vc_plane_scheduler_if.master) - request/handshake bundle
//           packetCountVC - per-VC completed-packet counters, present only
//                           when VC_PACKET_COUNT_EN is defined
// Options : `define VC_PACKET_COUNT_EN adds saturating per-VC tail-fire
//           counters of COUNT_WIDTH bits each.
module vc_plane_scheduler #(
  parameter int unsigned VC          = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  vc_plane_scheduler_if.master          bus
`ifdef VC_PACKET_COUNT_EN
  ,
  output logic [VC*COUNT_WIDTH-1:0]     packetCountVC
`endif
);

  localparam int unsigned IDX_W     = (VC > 1) ? $clog2(VC) : 1;
  localparam int unsigned SEL_OUT_W = VC + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [VC-1:0]     grant_q, grant_d;

  logic [IDX_W-1:0]  winner;
  logic              winner_found;
  logic [IDX_W-1:0]  scan_idx;
  logic              fire;
  logic              tail_fire;

  // First requesting plane scanning upward from rr_q with wrap.
  always_comb begin
    winner       = rr_q;
    winner_found = 1'b0;
    scan_idx     = '0;
    for (int unsigned off = 0; off < VC; off++) begin
      scan_idx = IDX_W'((32'(rr_q) + off) % VC);
      if (!winner_found && bus.vcRequest[scan_idx]) begin
        winner       = scan_idx;
        winner_found = 1'b1;
      end
    end
  end

  // Handshake outputs follow the locked plane combinationally.
  always_comb begin
    bus.vcReady     = '0;
    bus.switchValid = 1'b0;
    if (state_q == LOCKED) begin
      bus.vcReady[sel_q] = bus.switchReady;
      bus.switchValid    = bus.vcRequest[sel_q];
    end
  end

  assign fire      = bus.switchValid & bus.switchReady;
  assign tail_fire = fire & bus.vcTail[sel_q];

  // Next-state logic; the selector holds across IDLE so the mux stays stable.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (winner_found) begin
          state_d = LOCKED;
          sel_d   = winner;
          grant_d = VC'(1) << winner;
        end
      end
      LOCKED: begin
        if (tail_fire) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = (sel_q == IDX_W'(VC - 1)) ? '0 : sel_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  assign bus.VCPlaneSelector = SEL_OUT_W'(sel_q);
  assign bus.vcGrant         = grant_q;
  assign bus.schedulerBusy   = (state_q == LOCKED);

`ifdef VC_PACKET_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q [VC];
  logic [COUNT_WIDTH-1:0] cnt_d [VC];

  // Saturating count of completed packets per plane.
  always_comb begin
    cnt_d = cnt_q;
    if (tail_fire && (cnt_q[sel_q] != '1)) begin
      cnt_d[sel_q] = cnt_q[sel_q] + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < VC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < VC; g++) begin : g_count_out
    assign packetCountVC[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[g];
  end
`else
  // COUNT_WIDTH only sizes the optional counters; this block just anchors it.
  if (COUNT_WIDTH == 0) begin : g_no_count_width
  end
`endif

endmodule
